// File: rtl/uart_periph_pkg.sv
// ---------------------------------------------------------------------------
// uart_periph_pkg
// Shared definitions for the memory-mapped UART peripheral:
//   - bus addresses of the TXD / RXD / CON registers
//   - bit positions inside the CON register
//   - the state type used by both the TX and RX frame FSMs
// ---------------------------------------------------------------------------
package uart_periph_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_IE      = 0;
    localparam int CON_RX_IE      = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_VALID   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive path of the UART peripheral: two-flop synchroniser on the serial
// input, falling-edge start detection and an 8N1 frame FSM.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_in        raw asynchronous serial input (idle high)
//   rx_byte      last assembled data byte (valid when rx_done=1)
//   rx_done      1-cycle pulse: frame with a good stop bit completed
//   rx_frame_err 1-cycle pulse: frame ended with a low stop bit
// ---------------------------------------------------------------------------
module uart_rx
    import uart_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_frame_err
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

    logic [1:0]       sync_reg;
    logic             rx_prev_reg;
    logic             rx_s;
    uart_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
        end else begin
            sync_reg    <= {sync_reg[0], rx_in};
            rx_prev_reg <= rx_s;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        rx_done      = 1'b0;
        rx_frame_err = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                // Edge rather than level: a line held low after a bad frame
                // must not retrigger reception.
                if (rx_prev_reg && !rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};   // LSB arrives first
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    state_next   = ST_IDLE;
                    rx_done      = rx_s;
                    rx_frame_err = !rx_s;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rx_byte = shift_reg;

endmodule

// File: rtl/uart_periph.sv
// ---------------------------------------------------------------------------
// uart_periph
// Memory-mapped 8N1 UART for the pipeline's MEM stage. Holds the TX frame
// FSM and the TXD/RXD/CON register file; reception is done in uart_rx.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   rd, wr   bus read / write strobes (MemRd / MemWr)
//   addr     byte address
//   wdata    store data
//   rdata    combinational read data (0 when not selected)
//   uart_rx  serial input (asynchronous, idle high)
//   uart_tx  serial output (idle high)
//   irq      level interrupt: (tx_ie & tx_done) | (rx_ie & rx_valid)
// ---------------------------------------------------------------------------
module uart_periph
    import uart_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Bus decode
    logic txd_wr, con_wr, con_rd, rxd_rd;
    assign txd_wr = wr && (addr == ADDR_TXD);
    assign con_wr = wr && (addr == ADDR_CON);
    assign con_rd = rd && (addr == ADDR_CON);
    assign rxd_rd = rd && (addr == ADDR_RXD);

    // TX frame FSM
    uart_state_t      tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       txd_reg, txd_next;
    logic             tx_finish;
    logic             tx_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            txd_reg      <= txd_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        txd_next      = txd_reg;
        tx_finish     = 1'b0;
        case (tx_state_reg)
            ST_IDLE: begin
                tx_cnt_next = '0;
                tx_bit_next = '0;
                // TXD writes are only accepted here, so a write during a
                // frame is simply dropped.
                if (txd_wr) begin
                    txd_next      = wdata[7:0];
                    tx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = ST_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = ST_STOP;
                    end else begin
                        tx_bit_next = tx_bit_reg + 3'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = ST_IDLE;
                    tx_finish     = 1'b1;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CNT_W'(1);
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase
    end

    assign tx_busy = (tx_state_reg != ST_IDLE);

    // Line driven straight from state so reset forces it high immediately.
    always_comb begin
        uart_tx = 1'b1;
        case (tx_state_reg)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = txd_reg[tx_bit_reg];
            default:  uart_tx = 1'b1;
        endcase
    end

    // RX path
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (uart_rx),
        .rx_byte      (rx_byte),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err)
    );

    // Register file / status flags. In every flag, the set event has
    // priority over a coincident clear-on-read.
    logic       tx_ie_reg, rx_ie_reg;
    logic       tx_done_reg, rx_valid_reg, rx_overrun_reg;
    logic [7:0] rxd_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ie_reg      <= 1'b0;
            rx_ie_reg      <= 1'b0;
            tx_done_reg    <= 1'b0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
            rxd_reg        <= '0;
        end else begin
            if (con_wr) begin
                tx_ie_reg <= wdata[CON_TX_IE];
                rx_ie_reg <= wdata[CON_RX_IE];
            end

            if (tx_finish) begin
                tx_done_reg <= 1'b1;
            end else if (con_rd) begin
                tx_done_reg <= 1'b0;
            end

            if (rx_done) begin
                rxd_reg      <= rx_byte;
                rx_valid_reg <= 1'b1;
            end else if (rxd_rd) begin
                rx_valid_reg <= 1'b0;
            end

            // An RXD read in the completion cycle consumes the old byte,
            // so the new one is not an overrun.
            if (rx_done && rx_valid_reg && !rxd_rd) begin
                rx_overrun_reg <= 1'b1;
            end else if (con_rd) begin
                rx_overrun_reg <= 1'b0;
            end
        end
    end

    logic [31:0] con_value;
    always_comb begin
        con_value                 = '0;
        con_value[CON_TX_IE]      = tx_ie_reg;
        con_value[CON_RX_IE]      = rx_ie_reg;
        con_value[CON_TX_DONE]    = tx_done_reg;
        con_value[CON_RX_VALID]   = rx_valid_reg;
        con_value[CON_TX_BUSY]    = tx_busy;
        con_value[CON_RX_OVERRUN] = rx_overrun_reg;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (addr == ADDR_RXD) begin
                rdata = {24'h0, rxd_reg};
            end else if (addr == ADDR_CON) begin
                rdata = con_value;
            end
        end
    end

    assign irq = (tx_ie_reg & tx_done_reg) | (rx_ie_reg & rx_valid_reg);

    // Upper store-data bits and frame errors have no effect on any state.
    logic unused_bits;
    assign unused_bits = &{1'b0, wdata[31:8], rx_frame_err};

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clocks per UART bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Port clk  input  1  system clock, all state on rising edge.
REQ-003 Port reset  input  1  asynchronous active-low reset.
REQ-004 Port rd  input  1  bus read strobe from EX/MEM stage (MemRd).
REQ-005 Port wr  input  1  bus write strobe from EX/MEM stage (MemWr).
REQ-006 Port addr  input  32  byte address (EX/MEM ALU result).
REQ-007 Port wdata  input  32  store data.
REQ-008 Port rdata  output  32  read data to MEM/WB mux.
REQ-009 Port uart_rx  input  1  serial input, asynchronous, idle high.
REQ-010 Port uart_tx  output  1  serial output, idle high.
REQ-011 Port irq  output  1  level interrupt to control unit.

Function
REQ-012 Register map: TXD 0x40000018 (W, bits[7:0]), RXD 0x4000001C (R, bits[7:0]), CON 0x40000020 (R/W); other addresses ignored.
REQ-013 CON bits: [0] tx_ie, [1] rx_ie (R/W); [2] tx_done, [3] rx_valid, [4] tx_busy, [5] rx_overrun (R only, writes ignored); [31:6] read 0.
REQ-014 rdata combinational, zero-latency: selected register when rd=1 and addr matches, else 32'h0.
REQ-015 Side effects of reads (clear-on-read) take effect on the rising edge ending the rd cycle.
REQ-016 TX FSM states IDLE, START, DATA, STOP; 10 bits per frame, LSB first, one stop bit, no parity.
REQ-017 Write to TXD in IDLE: latch wdata[7:0], tx_busy=1, enter START next cycle; each state bit lasts exactly CLKS_PER_BIT clocks.
REQ-018 Write to TXD while tx_busy=1 is dropped; frame in flight unaffected.
REQ-019 At end of STOP: return IDLE, tx_busy=0, tx_done=1 in same edge.
REQ-020 Read of CON clears tx_done and rx_overrun; if a set event coincides with the clearing read, set wins.
REQ-021 uart_rx passes a 2-flop synchroniser before any use.
REQ-022 RX FSM states IDLE, START, DATA, STOP; falling edge in IDLE enters START.
REQ-023 START samples at CLKS_PER_BIT/2 (integer division); line high there -> glitch, back to IDLE, no flag change.
REQ-024 DATA samples 8 bits each CLKS_PER_BIT after previous sample, LSB first.
REQ-025 STOP sample high: store byte in RXD, rx_valid=1; STOP sample low: frame discarded, no flag change; both return IDLE.
REQ-026 Byte completes while rx_valid=1: RXD overwritten, rx_overrun=1.
REQ-027 Read of RXD clears rx_valid; completion coinciding with RXD read: new byte stored, rx_valid stays 1, no overrun.
REQ-028 irq = (tx_ie & tx_done) | (rx_ie & rx_valid), registered-free combinational from flags.
REQ-029 Bit-period counters width ceil(log2(CLKS_PER_BIT)), reset to 0 on every state transition; no wrap beyond CLKS_PER_BIT-1.
REQ-030 Simultaneous rd and wr on same address: write takes effect, read returns pre-edge value.

Reset
REQ-031 reset low asynchronously forces both FSMs IDLE, all counters 0, CON=0, TXD/RXD latches 0, synchroniser flops 1.
REQ-032 During and after reset: uart_tx=1, irq=0, rdata follows REQ-014 from reset values.
REQ-033 Reset mid-frame aborts the frame with no flag set; uart_tx returns high immediately.

Structure
REQ-034 Shared package holds register address constants, CON bit-position constants and FSM state typedefs.
REQ-035 RX path is one sub-module uart_rx (synchroniser, FSM, byte out plus 1-cycle done pulse plus frame-error pulse); TX and register file stay in uart_periph.

Verification (bench uses CLKS_PER_BIT=4)
REQ-036 Write TXD=0xA5, tx_ie=1 -> uart_tx low 4 clk, then 1,0,1,0,0,1,0,1 at 4 clk each, high 4 clk; tx_done=1, irq=1; CON read clears irq.
REQ-037 Write TXD=0x11 then TXD=0x22 two cycles later -> only 0x11 frame transmitted.
REQ-038 Drive frame 0x3C on uart_rx, rx_ie=1 -> rx_valid=1, irq=1, RXD read returns 0x0000003C, rx_valid then 0.
REQ-039 Two frames 0x01, 0x02 without RXD read -> RXD=0x02, CON[5]=1; 1-clock low glitch on idle line -> no flag change.
REQ-040 Assert reset mid TX frame -> uart_tx=1 same cycle, CON reads 0, next TXD write sends full clean frame.
